id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register and operand-select stage; directly upstream of the ALU.
//  - Latches decoded fields, then forwards and muxes them into the ALU OP/A/B inputs.
//  - Detects load-use hazards and inserts bubbles.
// PARAMETERS
//  XLEN     32  datapath width
//  REG_AW   5   register index width
// PORTS
//  CLK           in   1       clock; all state updates on posedge
//  RST           in   1       reset, synchronous, active-high
//  stall_in      in   1       downstream hold; EX register keeps its contents
//  flush_in      in   1       branch/jump redirect; EX register loads a bubble
//  id_valid      in   1       decode slot holds a real instruction
//  id_alu_op     in   5       ALU opcode (ALU encoding, 5'b00000=add .. 5'b10000=jalr)
//  id_rs1_data   in   XLEN    regfile read port 1
//  id_rs2_data   in   XLEN    regfile read port 2
//  id_imm        in   XLEN    sign-extended immediate
//  id_pc         in   XLEN    instruction PC
//  id_rs1/id_rs2 in   REG_AW  source register indices
//  id_rd         in   REG_AW  destination register index
//  id_use_imm    in   1       B operand = imm
//  id_use_pc     in   1       A operand = pc
//  id_reg_write  in   1       instruction writes rd
//  id_mem_read   in   1       instruction is a load
//  mem_rd,mem_reg_write,mem_result  in  REG_AW,1,XLEN  EX/MEM writeback candidate
//  wb_rd,wb_reg_write,wb_result     in  REG_AW,1,XLEN  MEM/WB writeback candidate
//  ex_valid      out  1       EX slot valid
//  ex_alu_op     out  5       to ALU OP
//  ex_a / ex_b   out  XLEN    to ALU A / B
//  ex_store_data out  XLEN    forwarded rs2 value, for stores
//  ex_rd         out  REG_AW  registered rd
//  ex_reg_write  out  1       registered reg_write, gated by ex_valid
//  ex_mem_read   out  1       registered mem_read, gated by ex_valid
//  hazard_stall  out  1       decode/fetch must hold this cycle
// BEHAVIOUR
//  - Reset: all registered fields 0.
//    => ex_valid=0, ex_alu_op=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0, hazard_stall=0.
//    ex_a/ex_b/ex_store_data show only the mux of zeroed registers and forwarding inputs; benches check them only when ex_valid=1.
//  - Latency: 1 cycle from id_* to the registered EX fields. Forwarding and operand muxes are combinational after the register.
//  - Posedge update priority: RST > flush_in > stall_in > hazard bubble > load.
//    - flush_in: load a bubble. Same-cycle stall_in is overridden.
//    - stall_in (no flush): hold every registered field.
//    - Bubble: valid=0, alu_op=5'b00000, rd=0, reg_write=0, mem_read=0.
//  - Load-use hazard:
//    hazard_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
//    - When set, and neither flush_in nor stall_in is active, a bubble is loaded; decode holds.
//    - Deasserts the next cycle, because the bubble has mem_read=0.
//    - When flush_in is set, hazard_stall is forced to 0.
//    - During stall_in, hazard_stall stays at its combinational value; the EX register holds.
//  - Forwarding, per source s (rs1/rs2) with registered data d:
//    - mem_reg_write & mem_rd!=0 & mem_rd==ex_rs  -> mem_result
//    - else wb_reg_write & wb_rd!=0 & wb_rd==ex_rs -> wb_result
//    - else d
//    - x0 is never forwarded. MEM has priority over WB on a double match.
//  - Operand muxes:
//    - ex_a = use_pc ? pc : fwd_rs1
//    - ex_b = use_imm ? imm : fwd_rs2
//    - ex_store_data = fwd_rs2, always
//  - Width: all paths XLEN bits, no extension or truncation; imm arrives pre-extended.
//  - Mid-operation reset: the next posedge clears state regardless of stall_in/flush_in.
// CONFIGURATION
//  IDEX_FORWARD_EN defined (default build):
//    - forwarding as above; hazard_stall covers load-use only.
//  IDEX_FORWARD_EN undefined:
//    - mem_*/wb_* data ignored; ex_a/ex_b/ex_store_data use registered regfile data only.
//    - hazard_stall asserts for any RAW between id_rs1/id_rs2 and a nonzero rd in EX, MEM or WB, where that stage's reg_write=1.
//    - Every hazard bubble follows the load-use bubble rules.
// TESTING
//  1 RST=1 for 2 cycles -> ex_valid=0, ex_alu_op=0, ex_rd=0, hazard_stall=0.
//  2 id add, rs1_data=5, imm=7, use_imm=1 -> next cycle ex_alu_op=0, ex_a=5, ex_b=7, ex_valid=1.
//  3 EX has x3; mem_rd=3 mem_result=0xAA; wb_rd=3 wb_result=0xBB -> ex_a=0xAA, MEM wins.
//    With rs1=x0 and mem_rd=0 -> no forwarding.
//  4 EX load rd=x4; id uses rs2=x4 -> hazard_stall=1, one bubble in EX.
//    The following cycle hazard_stall=0, and the consumer receives wb_result via forwarding.
//  5 stall_in=1 for 3 cycles with id changing -> EX fields constant.
//    flush_in=1 together with stall_in=1 -> ex_valid=0 next cycle.
//  6 Build without IDEX_FORWARD_EN: MEM stage writes x5, id reads x5 -> hazard_stall=1 until MEM and WB no longer hold x5.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: latches decoded fields, forwards/muxes ALU operands, inserts hazard bubbles.
// Define IDEX_FORWARD_EN for MEM/WB forwarding with load-use stalls; otherwise every RAW hazard stalls.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              id_valid,
  input  logic [4:0]        id_alu_op,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_imm,
  input  logic              id_use_pc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  output logic [4:0]        ex_alu_op,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              hazard_stall
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        alu_op;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              use_imm;
    logic              use_pc;
    logic              reg_write;
    logic              mem_read;
  } ex_fields_t;

  ex_fields_t        ex_q, ex_d, id_fields;
  logic              hazard_raw;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

  function automatic logic raw_hit(input logic [REG_AW-1:0] rd, input logic wr,
                                   input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
    return wr && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  always_comb begin
    id_fields           = '0;
    id_fields.valid     = id_valid;
    id_fields.alu_op    = id_alu_op;
    id_fields.rs1_data  = id_rs1_data;
    id_fields.rs2_data  = id_rs2_data;
    id_fields.imm       = id_imm;
    id_fields.pc        = id_pc;
    id_fields.rs1       = id_rs1;
    id_fields.rs2       = id_rs2;
    id_fields.rd        = id_rd;
    id_fields.use_imm   = id_use_imm;
    id_fields.use_pc    = id_use_pc;
    id_fields.reg_write = id_reg_write;
    id_fields.mem_read  = id_mem_read;
  end

  always_comb begin
    hazard_raw = 1'b0;
`ifdef IDEX_FORWARD_EN
    hazard_raw = raw_hit(ex_q.rd, ex_q.valid & ex_q.mem_read, id_rs1, id_rs2);
`else
    hazard_raw = raw_hit(ex_q.rd, ex_q.valid & ex_q.reg_write, id_rs1, id_rs2)
               | raw_hit(mem_rd, mem_reg_write, id_rs1, id_rs2)
               | raw_hit(wb_rd, wb_reg_write, id_rs1, id_rs2);
`endif
    // a redirect discards the decode slot, so it can never be the cause of a stall
    hazard_stall = id_valid & hazard_raw & ~flush_in;
  end

  always_comb begin
    ex_d = id_fields;
    if (flush_in)          ex_d = '0;
    else if (stall_in)     ex_d = ex_q;
    else if (hazard_stall) ex_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) ex_q <= '0;
    else     ex_q <= ex_d;
  end

`ifdef IDEX_FORWARD_EN
  // MEM is younger than WB, so it wins when both target the same register
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    fwd_rs2 = ex_q.rs2_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs1))     fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_q.rs1))   fwd_rs1 = wb_result;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs2))     fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_q.rs2))   fwd_rs2 = wb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_result, wb_result, ex_q.rs1, ex_q.rs2};

  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    fwd_rs2 = ex_q.rs2_data;
  end
`endif

  assign ex_valid      = ex_q.valid;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write & ex_q.valid;
  assign ex_mem_read   = ex_q.mem_read & ex_q.valid;
  assign ex_a          = ex_q.use_pc ? ex_q.pc : fwd_rs1;
  assign ex_b          = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model + scoreboard, vector table, directed corner sequences.
`timescale 1ns/1ps
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
`ifdef IDEX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST, stall_in, flush_in, id_valid, id_use_imm, id_use_pc, id_reg_write, id_mem_read;
  logic [4:0] id_alu_op;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc, mem_result, wb_result;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic mem_reg_write, wb_reg_write;
  logic ex_valid, ex_reg_write, ex_mem_read, hazard_stall;
  logic [4:0] ex_alu_op;
  logic [XLEN-1:0] ex_a, ex_b, ex_store_data;
  logic [REG_AW-1:0] ex_rd;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .CLK(CLK), .RST(RST), .stall_in(stall_in), .flush_in(flush_in), .id_valid(id_valid),
    .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_imm(id_use_imm), .id_use_pc(id_use_pc), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .hazard_stall(hazard_stall)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rst, stall, flush, idv;
    logic [4:0] op;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic [4:0] rs1, rs2, rd;
    logic use_imm, use_pc, rw, mr;
    logic [4:0] mem_rd;
    logic mem_rw;
    logic [31:0] mem_res;
    logic [4:0] wb_rd;
    logic wb_rw;
    logic [31:0] wb_res;
  } vec_t;

  typedef struct packed {
    vec_t v;
    logic hz;
  } tbl_t;

  int checks = 0;
  int failures = 0;
  vec_t m = '0;
  bit m_known = 1'b0;
  logic [12:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic raw(input logic [4:0] rd, input logic wr, input vec_t v);
    return wr && (rd != 5'd0) && ((rd == v.rs1) || (rd == v.rs2));
  endfunction

  function automatic logic model_hz(input vec_t s, input vec_t v);
    if (v.flush || !v.idv) return 1'b0;
    if (FWD) return s.idv && s.mr && (s.rd != 5'd0) && ((v.rs1 == s.rd) || (v.rs2 == s.rd));
    return raw(s.rd, s.idv && s.rw, v) || raw(v.mem_rd, v.mem_rw, v) || raw(v.wb_rd, v.wb_rw, v);
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] d, input vec_t v);
    if (FWD && v.mem_rw && (v.mem_rd != 5'd0) && (v.mem_rd == rs)) return v.mem_res;
    if (FWD && v.wb_rw && (v.wb_rd != 5'd0) && (v.wb_rd == rs)) return v.wb_res;
    return d;
  endfunction

  task automatic drive(input vec_t v);
    RST = v.rst; stall_in = v.stall; flush_in = v.flush; id_valid = v.idv;
    id_alu_op = v.op; id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm; id_pc = v.pc;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_use_imm = v.use_imm; id_use_pc = v.use_pc;
    id_reg_write = v.rw; id_mem_read = v.mr;
    mem_rd = v.mem_rd; mem_reg_write = v.mem_rw; mem_result = v.mem_res;
    wb_rd = v.wb_rd; wb_reg_write = v.wb_rw; wb_result = v.wb_res;
  endtask

  // One clock: compare registered outputs against the scoreboard, drive, check combinational outputs.
  task automatic cycle(input vec_t v);
    logic [12:0] e;
    logic h;
    vec_t nx;
    @(negedge CLK);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_regs", {19'd0, ex_valid, ex_alu_op, ex_rd, ex_reg_write, ex_mem_read}, {19'd0, e});
    end
    drive(v);
    h = model_hz(m, v);
    #2;
    if (m_known && !v.rst) begin
      chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, h});
      if (m.idv) begin
        chk("ex_a", ex_a, m.use_pc ? m.pc : model_fwd(m.rs1, m.rs1d, v));
        chk("ex_b", ex_b, m.use_imm ? m.imm : model_fwd(m.rs2, m.rs2d, v));
        chk("ex_store_data", ex_store_data, model_fwd(m.rs2, m.rs2d, v));
      end
    end
    if (v.rst)        nx = '0;
    else if (v.flush) nx = '0;
    else if (v.stall) nx = m;
    else if (h)       nx = '0;
    else              nx = v;
    m = nx;
    if (v.rst) m_known = 1'b1;
    if (m_known) sb.push_back({m.idv, m.op, m.rd, m.rw & m.idv, m.mr & m.idv});
  endtask

  initial begin
    vec_t n, v, u;
    tbl_t tbl[8];
    n = '0;

    // vector table: hand-derived hazard_stall per cycle, starting from a freshly reset EX slot
    for (int i = 0; i < 8; i++) tbl[i] = '0;
    tbl[0].v.idv = 1; tbl[0].v.rs1 = 1; tbl[0].v.rd = 2; tbl[0].v.rw = 1; tbl[0].v.mr = 1;
    tbl[0].hz = 1'b0;
    tbl[1].v.idv = 1; tbl[1].v.rs1 = 2; tbl[1].v.rs2 = 3; tbl[1].v.rd = 5; tbl[1].v.rw = 1;
    tbl[1].v.flush = 1; tbl[1].hz = 1'b0;
    tbl[2].v = tbl[1].v; tbl[2].v.flush = 0; tbl[2].v.mem_rd = 2; tbl[2].v.mem_rw = 1;
    tbl[2].v.mem_res = 32'h1234_5678; tbl[2].hz = FWD ? 1'b0 : 1'b1;
    tbl[3].v.idv = 1; tbl[3].v.rw = 1; tbl[3].v.mr = 1; tbl[3].v.wb_rw = 1; tbl[3].hz = 1'b0;
    tbl[4].v.idv = 1; tbl[4].v.rd = 6; tbl[4].v.rw = 1; tbl[4].v.op = 5'd3; tbl[4].hz = 1'b0;
    tbl[5].v.rs1 = 6; tbl[5].hz = 1'b0;
    tbl[6].v.idv = 1; tbl[6].v.rs2 = 7; tbl[6].v.wb_rd = 7; tbl[6].v.wb_rw = 1;
    tbl[6].hz = FWD ? 1'b0 : 1'b1;
    tbl[7].v.idv = 1; tbl[7].v.rs1 = 8; tbl[7].v.mem_rd = 8; tbl[7].v.wb_rd = 8; tbl[7].hz = 1'b0;

    // reset: two cycles
    v = n; v.rst = 1;
    cycle(v); cycle(v);
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_alu_op", {27'd0, ex_alu_op}, 32'd0);
    chk("rst_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);

    // add with immediate operand
    v = n; v.idv = 1; v.rs1d = 5; v.imm = 7; v.use_imm = 1; v.rs1 = 1; v.rs2 = 2; v.rd = 6; v.rw = 1;
    cycle(v); cycle(n);
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_op", {27'd0, ex_alu_op}, 32'd0);
    chk("add_a", ex_a, 32'd5);
    chk("add_b", ex_b, 32'd7);

    // MEM vs WB priority, WB-only match, and x0
    v = n; v.idv = 1; v.rs1 = 3; v.rs1d = 32'h11;
    cycle(v);
    v = n; v.mem_rd = 3; v.mem_rw = 1; v.mem_res = 32'hAA; v.wb_rd = 3; v.wb_rw = 1; v.wb_res = 32'hBB;
    cycle(v);
    chk("fwd_mem_wins", ex_a, FWD ? 32'hAA : 32'h11);
    v = n; v.idv = 1; v.rs1 = 3; v.rs1d = 32'h11;
    cycle(v);
    v = n; v.mem_rd = 3; v.mem_res = 32'hAA; v.wb_rd = 3; v.wb_rw = 1; v.wb_res = 32'hBB;
    cycle(v);
    chk("fwd_wb_only", ex_a, FWD ? 32'hBB : 32'h11);
    v = n; v.idv = 1; v.rs1 = 0; v.rs1d = 32'h22;
    cycle(v);
    v = n; v.mem_rw = 1; v.mem_res = 32'hAA; v.wb_rw = 1; v.wb_res = 32'hBB;
    cycle(v);
    chk("fwd_x0", ex_a, 32'h22);

    // load x4 followed by a consumer of x4
    v = n; v.idv = 1; v.rs1 = 1; v.rd = 4; v.rw = 1; v.mr = 1;
    cycle(v);
    u = n; u.idv = 1; u.rs2 = 4; u.rd = 7; u.rw = 1; u.rs2d = 32'h33;
    cycle(u);
    chk("lu_hazard", {31'd0, hazard_stall}, 32'd1);
    v = u; v.mem_rd = 4; v.mem_rw = 1; v.mem_res = 32'h40;
    cycle(v);
`ifdef IDEX_FORWARD_EN
    chk("lu_release", {31'd0, hazard_stall}, 32'd0);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    v = n; v.wb_rd = 4; v.wb_rw = 1; v.wb_res = 32'h44;
    cycle(v);
    chk("lu_fwd_wb", ex_store_data, 32'h44);
    chk("lu_rd", {27'd0, ex_rd}, 32'd7);
`else
    chk("raw_mem", {31'd0, hazard_stall}, 32'd1);
    v = u; v.wb_rd = 4; v.wb_rw = 1; v.wb_res = 32'h44;
    cycle(v);
    chk("raw_wb", {31'd0, hazard_stall}, 32'd1);
    cycle(u);
    chk("raw_clear", {31'd0, hazard_stall}, 32'd0);
    cycle(n);
    chk("raw_valid", {31'd0, ex_valid}, 32'd1);
    chk("raw_data", ex_store_data, 32'h33);
`endif

    // stall holds EX for three cycles; flush overrides stall
    v = n; v.idv = 1; v.op = 5'd5; v.rd = 9; v.rw = 1; v.rs1 = 1; v.rs2 = 2; v.rs1d = 32'h55;
    cycle(v);
    for (int i = 0; i < 3; i++) begin
      v = n; v.stall = 1; v.idv = 1; v.op = 5'(i + 1); v.rd = 5'(10 + i); v.rs1 = 1; v.rs2 = 2;
      v.rs1d = 32'(i);
      cycle(v);
      chk("stall_op", {27'd0, ex_alu_op}, 32'd5);
      chk("stall_rd", {27'd0, ex_rd}, 32'd9);
      chk("stall_a", ex_a, 32'h55);
    end
    v = n; v.stall = 1; v.flush = 1; v.idv = 1; v.op = 5'd3;
    cycle(v);
    chk("stall_held", {27'd0, ex_alu_op}, 32'd5);
    cycle(n);
    chk("flush_over_stall", {31'd0, ex_valid}, 32'd0);

    // reset during stall
    v = n; v.idv = 1; v.op = 5'd2; v.rd = 3; v.rw = 1;
    cycle(v);
    v.stall = 1; v.rst = 1;
    cycle(v);
    cycle(n);
    chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("mid_rst_rd", {27'd0, ex_rd}, 32'd0);

    v = n; v.rst = 1;
    cycle(v);
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].v);
      chk($sformatf("tbl_hz_%0d", i), {31'd0, hazard_stall}, {31'd0, tbl[i].hz});
    end

    // random traffic over a small register window to provoke matches
    for (int i = 0; i < 400; i++) begin
      v = '0;
      v.rst = ($urandom_range(0, 49) == 0);
      v.stall = ($urandom_range(0, 5) == 0);
      v.flush = ($urandom_range(0, 9) == 0);
      v.idv = ($urandom_range(0, 3) != 0);
      v.op = 5'($urandom_range(0, 16));
      v.rs1d = $urandom; v.rs2d = $urandom; v.imm = $urandom; v.pc = $urandom;
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3)); v.rd = 5'($urandom_range(0, 3));
      v.use_imm = 1'($urandom_range(0, 1)); v.use_pc = 1'($urandom_range(0, 1));
      v.rw = 1'($urandom_range(0, 1)); v.mr = 1'($urandom_range(0, 1));
      v.mem_rd = 5'($urandom_range(0, 3)); v.mem_rw = 1'($urandom_range(0, 1)); v.mem_res = $urandom;
      v.wb_rd = 5'($urandom_range(0, 3)); v.wb_rw = 1'($urandom_range(0, 1)); v.wb_res = $urandom;
      cycle(v);
    end
    cycle(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
